// File: rtl/regalu_sequencer.sv
// regalu_sequencer: issue controller for the regfile + pipelined-ALU datapath
//
// Accepts one ALU instruction per cycle (instr_valid/instr_ready) and drives
// the regfile/alupipe pair directly:
//   clk, reset              rising-edge clock, synchronous active-high reset
//   instr_valid/ready       instruction handshake
//   instr_op/cin            ALU function (alupipe S encoding, 111 = NOP), carry-in
//   instr_ra/rb/rd          source A, source B, destination register indices
//   Aselect/Bselect         one-hot read selects for the op in its issue cycle
//   Dselect                 one-hot write select, DEPTH_WB cycles after issue
//   S, Cin                  ALU function and carry-in for the issuing op
//   busy                    some op has issued but not yet reached write-back
//   issue_count             accepted instructions, wrapping
//   stall_count             cycles with instr_valid && !instr_ready, wrapping
// There is no forwarding, so a reader of an in-flight destination is held
// off until the write-back cycle has passed.
module regalu_sequencer #(
    parameter int DEPTH_WB = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        instr_valid,
    output logic        instr_ready,
    input  logic [2:0]  instr_op,
    input  logic        instr_cin,
    input  logic [4:0]  instr_ra,
    input  logic [4:0]  instr_rb,
    input  logic [4:0]  instr_rd,
    output logic [31:0] Aselect,
    output logic [31:0] Bselect,
    output logic [31:0] Dselect,
    output logic [2:0]  S,
    output logic        Cin,
    output logic        busy,
    output logic [15:0] issue_count,
    output logic [15:0] stall_count
);
    localparam logic [2:0] NOP = 3'b111;

    // fv/frd[0] is the op in its issue cycle, frd[k] the op issued k cycles ago
    logic [DEPTH_WB-1:0] fv;
    logic [4:0]          frd [DEPTH_WB];
    logic [4:0]          sra, srb;
    logic [2:0]          sop;
    logic                scin;
    logic                rdy_en;
    logic                hazard;
    logic                acc;
    logic [31:0]         dsel;

    always_comb begin
        hazard = 1'b0;
        for (int i = 0; i < DEPTH_WB; i++)
            // a nonzero rd match implies the matching source is nonzero too
            if (fv[i] && frd[i] != 5'd0 && (instr_ra == frd[i] || instr_rb == frd[i]))
                hazard = 1'b1;
    end

    // NOPs read nothing, so they never wait on a hazard
    assign instr_ready = rdy_en && !reset && !(hazard && instr_op != NOP);
    assign acc         = instr_valid && instr_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            rdy_en      <= 1'b0;
            fv          <= '0;
            dsel        <= 32'd1;
            issue_count <= 16'd0;
            stall_count <= 16'd0;
        end else begin
            rdy_en      <= 1'b1;
            fv          <= {fv[DEPTH_WB-2:0], acc && instr_op != NOP};
            dsel        <= fv[DEPTH_WB-1] ? 32'd1 << frd[DEPTH_WB-1] : 32'd1;
            issue_count <= issue_count + {15'd0, acc};
            stall_count <= stall_count + {15'd0, instr_valid && !instr_ready};
        end
    end

    // payload registers need no reset: every use is gated by a valid bit
    always_ff @(posedge clk) begin
        frd[0] <= instr_rd;
        for (int i = 1; i < DEPTH_WB; i++)
            frd[i] <= frd[i-1];
        if (acc) begin
            sra  <= instr_ra;
            srb  <= instr_rb;
            sop  <= instr_op;
            scin <= instr_cin;
        end
    end

    // bubbles read and write R0 with a neutral XOR, keeping every select one-hot
    assign Aselect = fv[0] ? 32'd1 << sra : 32'd1;
    assign Bselect = fv[0] ? 32'd1 << srb : 32'd1;
    assign S       = fv[0] ? sop : 3'b000;
    assign Cin     = fv[0] && scin;
    assign Dselect = dsel;
    assign busy    = |fv;
endmodule

// File: tb/tb_regalu_sequencer.sv
// tb_regalu_sequencer: directed self-checking bench for regalu_sequencer
module tb_regalu_sequencer;
    logic        clk = 1'b0;
    logic        reset;
    logic        instr_valid;
    logic        instr_ready;
    logic [2:0]  instr_op;
    logic        instr_cin;
    logic [4:0]  instr_ra, instr_rb, instr_rd;
    logic [31:0] Aselect, Bselect, Dselect;
    logic [2:0]  S;
    logic        Cin;
    logic        busy;
    logic [15:0] issue_count, stall_count;
    int total = 0;
    int bad = 0;

    regalu_sequencer #(.DEPTH_WB(2)) dut (
        .clk(clk), .reset(reset), .instr_valid(instr_valid), .instr_ready(instr_ready),
        .instr_op(instr_op), .instr_cin(instr_cin), .instr_ra(instr_ra),
        .instr_rb(instr_rb), .instr_rd(instr_rd), .Aselect(Aselect), .Bselect(Bselect),
        .Dselect(Dselect), .S(S), .Cin(Cin), .busy(busy),
        .issue_count(issue_count), .stall_count(stall_count)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drv(input logic v, input logic [2:0] op, input logic c,
                       input logic [4:0] a, input logic [4:0] b, input logic [4:0] d);
        instr_valid = v;
        instr_op    = op;
        instr_cin   = c;
        instr_ra    = a;
        instr_rb    = b;
        instr_rd    = d;
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        // reset held 2 cycles with random inputs
        reset = 1'b1;
        drv(1'b1, 3'($urandom), 1'($urandom), 5'($urandom), 5'($urandom), 5'($urandom));
        chk("rst_ready_during", 32'(instr_ready), 32'd0);
        tick();
        drv(1'b1, 3'($urandom), 1'($urandom), 5'($urandom), 5'($urandom), 5'($urandom));
        chk("rst_asel", Aselect, 32'h1);
        chk("rst_bsel", Bselect, 32'h1);
        chk("rst_dsel", Dselect, 32'h1);
        tick();
        chk("rst_s", 32'(S), 32'd0);
        chk("rst_cin", 32'(Cin), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_icnt", 32'(issue_count), 32'd0);
        chk("rst_scnt", 32'(stall_count), 32'd0);
        reset = 1'b0;
        drv(1'b0, 3'd0, 1'b0, 5'd0, 5'd0, 5'd0);
        chk("ready_first_after_rst", 32'(instr_ready), 32'd0);
        tick();
        chk("ready_second_after_rst", 32'(instr_ready), 32'd1);

        // independent stream: XNOR R0,R0->R1 ; OR R2,R3->R4
        drv(1'b1, 3'b001, 1'b0, 5'd0, 5'd0, 5'd1);
        chk("ind_ready0", 32'(instr_ready), 32'd1);
        tick();
        drv(1'b1, 3'b100, 1'b0, 5'd2, 5'd3, 5'd4);
        chk("ind_ready1", 32'(instr_ready), 32'd1);
        chk("ind_asel0", Aselect, 32'h1);
        chk("ind_bsel0", Bselect, 32'h1);
        chk("ind_s0", 32'(S), 32'd1);
        tick();
        drv(1'b0, 3'd0, 1'b0, 5'd0, 5'd0, 5'd0);
        chk("ind_asel1", Aselect, 32'h4);
        chk("ind_bsel1", Bselect, 32'h8);
        chk("ind_s1", 32'(S), 32'd4);
        chk("ind_busy", 32'(busy), 32'd1);
        tick();
        chk("ind_dsel0", Dselect, 32'h2);
        chk("ind_icnt", 32'(issue_count), 32'd2);
        tick();
        chk("ind_dsel1", Dselect, 32'h10);
        tick();
        chk("ind_dsel_idle", Dselect, 32'h1);
        chk("ind_busy_idle", 32'(busy), 32'd0);
        chk("ind_scnt", 32'(stall_count), 32'd0);

        // distance-1 hazard: XNOR ->R1 ; AND R1,R0->R2
        drv(1'b1, 3'b001, 1'b0, 5'd0, 5'd0, 5'd1);
        tick();
        drv(1'b1, 3'b110, 1'b0, 5'd1, 5'd0, 5'd2);
        chk("d1_ready_c", 32'(instr_ready), 32'd0);
        tick();
        chk("d1_ready_c1", 32'(instr_ready), 32'd0);
        chk("d1_bubble_asel", Aselect, 32'h1);
        tick();
        chk("d1_ready_c2", 32'(instr_ready), 32'd1);
        chk("d1_scnt", 32'(stall_count), 32'd2);
        chk("d1_dsel", Dselect, 32'h2);
        tick();
        drv(1'b0, 3'd0, 1'b0, 5'd0, 5'd0, 5'd0);
        chk("d1_asel", Aselect, 32'h2);
        chk("d1_s", 32'(S), 32'd6);
        chk("d1_icnt", 32'(issue_count), 32'd4);
        tick();
        tick();
        chk("d1_dsel_and", Dselect, 32'h4);

        // distance-2 hazard: ADD ->R5 ; XOR R2,R3->R6 ; OR R0,R5->R7
        drv(1'b1, 3'b010, 1'b1, 5'd0, 5'd0, 5'd5);
        tick();
        drv(1'b1, 3'b000, 1'b0, 5'd2, 5'd3, 5'd6);
        chk("d2_cin", 32'(Cin), 32'd1);
        chk("d2_s_add", 32'(S), 32'd2);
        chk("d2_ready_xor", 32'(instr_ready), 32'd1);
        tick();
        drv(1'b1, 3'b100, 1'b0, 5'd0, 5'd5, 5'd7);
        chk("d2_ready_stall", 32'(instr_ready), 32'd0);
        tick();
        chk("d2_ready_go", 32'(instr_ready), 32'd1);
        chk("d2_dsel_r5", Dselect, 32'h20);
        chk("d2_scnt", 32'(stall_count), 32'd3);
        tick();
        drv(1'b0, 3'd0, 1'b0, 5'd0, 5'd0, 5'd0);
        chk("d2_bsel", Bselect, 32'h20);
        chk("d2_s_or", 32'(S), 32'd4);
        chk("d2_dsel_r6", Dselect, 32'h40);
        chk("d2_icnt", 32'(issue_count), 32'd7);
        tick();
        tick();
        chk("d2_dsel_r7", Dselect, 32'h80);

        // R0 destination, R0 reader, NOP whose sources alias an in-flight rd
        drv(1'b1, 3'b110, 1'b0, 5'd1, 5'd2, 5'd0);
        tick();
        drv(1'b1, 3'b000, 1'b0, 5'd0, 5'd0, 5'd3);
        chk("r0_ready", 32'(instr_ready), 32'd1);
        chk("r0_asel_and", Aselect, 32'h2);
        tick();
        drv(1'b1, 3'b111, 1'b1, 5'd3, 5'd3, 5'd5);
        chk("nop_ready", 32'(instr_ready), 32'd1);
        tick();
        drv(1'b0, 3'd0, 1'b0, 5'd0, 5'd0, 5'd0);
        chk("nop_asel", Aselect, 32'h1);
        chk("nop_s", 32'(S), 32'd0);
        chk("nop_cin", 32'(Cin), 32'd0);
        chk("nop_icnt", 32'(issue_count), 32'd10);
        chk("r0_dsel", Dselect, 32'h1);
        chk("nop_scnt", 32'(stall_count), 32'd3);
        tick();
        chk("r0_dsel_xor", Dselect, 32'h8);
        tick();
        chk("nop_dsel", Dselect, 32'h1);

        // reset mid-flight: ADD R1,R2->R7 with Cin=1, reset in C+1
        drv(1'b1, 3'b010, 1'b1, 5'd1, 5'd2, 5'd7);
        tick();
        drv(1'b0, 3'd0, 1'b0, 5'd0, 5'd0, 5'd0);
        chk("mf_cin", 32'(Cin), 32'd1);
        chk("mf_asel", Aselect, 32'h2);
        tick();
        reset = 1'b1;
        #1;
        tick();
        reset = 1'b0;
        #1;
        chk("mf_dsel", Dselect, 32'h1);
        chk("mf_busy", 32'(busy), 32'd0);
        chk("mf_asel_rst", Aselect, 32'h1);
        chk("mf_icnt", 32'(issue_count), 32'd0);
        tick();
        chk("mf_dsel_after", Dselect, 32'h1);
        tick();
        chk("mf_dsel_late", Dselect, 32'h1);
        chk("mf_ready", 32'(instr_ready), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
